frame_reader: RTL and testbench

- Read-side counterpart of the frame fill path: fetches an 800x600, 32-bit-per-pixel frame from DDR2 through the address FIFO and read-data FIFO.
- Buffers the returned data locally and streams 24-bit pixels in raster order to the video output stage over a valid/ready handshake.
- Scans frames continuously and repeats while enabled.
- Uses the same address map as the frame fill path, so a filled frame reads back pixel-exact.

---
 rtl/frame_reader.sv | 241 ++++++++++++++++++++++++
 tb/tb_frame_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
// -----------------------------------------------------------------------------
// frame_reader
//   Read side of the DDR2 frame path. Walks the frame in raster order, pushing
//   one read command per 8 pixels into the DDR2 address FIFO, buffers the two
//   128-bit words each command returns, and streams 24-bit pixels to the video
//   output stage over a valid/ready handshake. Frames repeat while enable=1.
//
// Ports
//   clk, rst          system clock, asynchronous active-low reset
//   enable            run request, sampled only at frame boundaries
//   FR_frame_base     frame base address, bits [27:22] used
//   af_full           DDR2 address FIFO full
//   af_addr_din       read address {6'd0, base, y, x[9:3], 2'b00}
//   af_wr_en          push a read command
//   af_cmd_din        command code, constant read (3'b001)
//   rdf_valid/dout    returned read-data word (no backpressure)
//   video             pixel colour
//   video_valid       pixel available (local buffer non-empty)
//   video_ready       consumer accepts pixel
//   video_sof         high while the head pixel is pixel (0,0) of a frame
//   busy              high while the request FSM is not idle
// -----------------------------------------------------------------------------
module frame_reader #(
    parameter int unsigned BUF_DEPTH = 32,
    parameter logic [9:0]  X_LAST    = 10'd792,
    parameter logic [9:0]  Y_LAST    = 10'd599
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [31:0]  FR_frame_base,
    input  logic         af_full,
    output logic [30:0]  af_addr_din,
    output logic         af_wr_en,
    output logic [2:0]   af_cmd_din,
    input  logic         rdf_valid,
    input  logic [127:0] rdf_dout,
    output logic [23:0]  video,
    output logic         video_valid,
    input  logic         video_ready,
    output logic         video_sof,
    output logic         busy
);

    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned RES_W     = PTR_W + 2;
    localparam int unsigned FRAME_PIX = (32'(X_LAST) + 32'd8) * (32'(Y_LAST) + 32'd1);
    localparam int unsigned PIX_W     = $clog2(FRAME_PIX);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WRAP} state_e;

    state_e             state_q, state_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic [5:0]         base_q, base_d;
    logic [CNT_W-1:0]   out_q, out_d;      // commands with words still due
    logic               half_q;            // first word of a pair already seen
    logic [CNT_W-1:0]   cnt_q, cnt_d;      // words held in the line buffer
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [1:0]         lane_q;            // pixel index within head word
    logic [PIX_W-1:0]   pix_q, pix_d;      // raster index of head pixel

    logic [95:0]        mem_q [BUF_DEPTH];
    logic [95:0]        rdf_pix;
    logic [95:0]        head_word;
    logic [23:0]        lane_pix;
    logic [RES_W-1:0]   reserved;
    logic               credit_ok;
    logic               ret_last;
    logic               xfer;
    logic               pop_word;
    logic               unused_bits;

    // Only the low 24 bits of each 32-bit lane carry colour; drop the rest
    // before storage.
    assign rdf_pix = {rdf_dout[119:96], rdf_dout[87:64], rdf_dout[55:32], rdf_dout[23:0]};
    assign unused_bits = ^{FR_frame_base[31:28], FR_frame_base[21:0],
                           rdf_dout[127:120], rdf_dout[95:88],
                           rdf_dout[63:56], rdf_dout[31:24]};

    // Every command in flight holds two buffer slots, so the buffer can never
    // be overrun by returning data.
    assign reserved  = RES_W'(cnt_q) + {out_q, 1'b0};
    assign credit_ok = (reserved + RES_W'(2)) <= RES_W'(BUF_DEPTH);
    assign ret_last  = rdf_valid && half_q;

    assign af_addr_din = {6'd0, base_q, y_q, x_q[9:3], 2'b00};
    assign af_cmd_din  = 3'b001;
    assign busy        = (state_q != S_IDLE);

    // -------------------------------------------------------------------------
    // Request FSM
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        base_d   = base_q;
        af_wr_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    base_d  = FR_frame_base[27:22];
                    x_d     = '0;
                    y_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (credit_ok && !af_full) begin
                    af_wr_en = 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = S_WRAP;
                        end else begin
                            y_d = y_q + 10'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd8;
                    end
                end
            end
            S_WRAP: begin
                // Base is only re-sampled once the old frame has fully drained.
                if (out_q == '0 && cnt_q == '0) begin
                    x_d = '0;
                    y_d = '0;
                    if (enable) begin
                        base_d  = FR_frame_base[27:22];
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Credit, buffer occupancy and pixel position
    // -------------------------------------------------------------------------
    assign video_valid = (cnt_q != '0);
    assign xfer        = video_valid && video_ready;
    assign pop_word    = xfer && (lane_q == 2'd3);
    assign video_sof   = video_valid && (pix_q == '0);

    always_comb begin
        out_d = out_q;
        if (af_wr_en && !ret_last) begin
            out_d = out_q + CNT_W'(1);
        end else if (!af_wr_en && ret_last) begin
            out_d = out_q - CNT_W'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rdf_valid && !pop_word) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!rdf_valid && pop_word) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        pix_d = pix_q;
        if (xfer) begin
            pix_d = (pix_q == PIX_W'(FRAME_PIX - 1)) ? '0 : pix_q + PIX_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            base_q   <= '0;
            out_q    <= '0;
            half_q   <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lane_q   <= '0;
            pix_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            out_q   <= out_d;
            half_q  <= half_q ^ rdf_valid;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            if (rdf_valid) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_word) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (xfer) begin
                lane_q <= lane_q + 2'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Line buffer storage and pixel unpack
    // -------------------------------------------------------------------------
    // NOTE: the storage array is deliberately left out of reset; pointers and
    // occupancy are reset, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (rdf_valid) begin
            mem_q[wr_ptr_q] <= rdf_pix;
        end
    end

    assign head_word = mem_q[rd_ptr_q];

    always_comb begin
        lane_pix = head_word[23:0];
        unique case (lane_q)
            2'd0: lane_pix = head_word[23:0];
            2'd1: lane_pix = head_word[47:24];
            2'd2: lane_pix = head_word[71:48];
            2'd3: lane_pix = head_word[95:72];
            default: lane_pix = head_word[23:0];
        endcase
    end

    // Gate with valid so the output is 0 whenever no pixel is presented.
    assign video = video_valid ? lane_pix : 24'd0;

endmodule

// File: tb/tb_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_frame_reader
//   Directed sequence with randomized phases for frame_reader, run on a short
//   frame (800 x 3) so several frames fit in the run. A DDR2 model answers each
//   read command with two words LAT cycles later; a raster model predicts every
//   address and every pixel from (x, y).
// -----------------------------------------------------------------------------
module tb_frame_reader;

    localparam int         BUF_DEPTH  = 32;
    localparam logic [9:0] XL         = 10'd792;
    localparam logic [9:0] YL         = 10'd2;
    localparam int         ROW_W      = 800;
    localparam int         ROWS       = 3;
    localparam int         FRAME_PIX  = ROW_W * ROWS;
    localparam int         ROW_CMDS   = ROW_W / 8;
    localparam int         FRAME_CMDS = ROW_CMDS * ROWS;
    localparam int         LAT        = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic [31:0]  FR_frame_base = '0;
    logic         af_full = 1'b0;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic [2:0]   af_cmd_din;
    logic         rdf_valid = 1'b0;
    logic [127:0] rdf_dout = '0;
    logic [23:0]  video;
    logic         video_valid;
    logic         video_ready = 1'b1;
    logic         video_sof;
    logic         busy;

    frame_reader #(.BUF_DEPTH(BUF_DEPTH), .X_LAST(XL), .Y_LAST(YL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .FR_frame_base(FR_frame_base),
        .af_full(af_full), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
        .af_cmd_din(af_cmd_din), .rdf_valid(rdf_valid), .rdf_dout(rdf_dout),
        .video(video), .video_valid(video_valid), .video_ready(video_ready),
        .video_sof(video_sof), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct { int t; logic [127:0] d; } word_t;
    word_t mq[$];

    int          cycle = 0;
    int          pix_idx = 0;       // raster index of the next pixel expected
    int          pix_out = 0;       // pixels transferred since reset
    int          words_in = 0;      // words delivered since reset
    int          pushes = 0;        // commands accepted since reset
    int          cmd_idx = 0;       // raster index of the next command expected
    int          frames_done = 0;
    int          first_wr_cyc = -1;
    int          pops_now = 0;
    logic [5:0]  fbase = '0;

    function automatic logic [31:0] mkbase(input logic [5:0] b);
        return {4'hC, b, 22'h2A5A5};
    endfunction

    function automatic logic [30:0] exp_addr(input logic [5:0] b, input int c);
        logic [9:0] y10;
        logic [6:0] x7;
        y10 = 10'(c / ROW_CMDS);
        x7  = 7'(c % ROW_CMDS);
        return {6'd0, b, y10, x7, 2'b00};
    endfunction

    function automatic logic [23:0] pixel(input int x, input int y);
        logic [7:0] xb, yb;
        xb = 8'(x);
        yb = 8'(y);
        return {xb, yb, 8'hA5};
    endfunction

    function automatic logic [127:0] mk_word(input int c, input int w);
        logic [127:0] d;
        for (int k = 0; k < 4; k++) begin
            d[32*k +: 24]    = pixel((c % ROW_CMDS) * 8 + w * 4 + k, c / ROW_CMDS);
            d[32*k + 24 +: 8] = 8'($urandom);
        end
        return d;
    endfunction

    // Outputs observed and memory responses driven on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
            pix_idx = 0; pix_out = 0; words_in = 0; pushes = 0; cmd_idx = 0;
            first_wr_cyc = -1;
            rdf_valid = 1'b0;
            rdf_dout  = '0;
        end else begin
            cycle++;
            if (first_wr_cyc >= 0 && cycle == first_wr_cyc + 1)
                check("first_pixel_latency", video_valid, 1);
            pops_now = pix_out / 4;
            if (video_valid) begin
                check("video", video, pixel(pix_idx % ROW_W, pix_idx / ROW_W));
                check("sof", video_sof, pix_idx == 0);
                if (video_ready) begin
                    pix_out++;
                    pix_idx++;
                    if (pix_idx == FRAME_PIX) begin
                        pix_idx = 0;
                        frames_done++;
                    end
                end
            end else begin
                check("sof_without_valid", video_sof, 0);
            end
            if (af_full)
                check("wr_en_while_full", af_wr_en, 0);
            if (af_wr_en) begin
                check("cmd_code", af_cmd_din, 3'b001);
                check("credit_bound", (2 * pushes - pops_now + 2) <= BUF_DEPTH, 1);
                if (cmd_idx == 0) fbase = FR_frame_base[27:22];
                check($sformatf("addr_%0d", cmd_idx), af_addr_din, exp_addr(fbase, cmd_idx));
                for (int w = 0; w < 2; w++)
                    mq.push_back('{t: cycle + LAT, d: mk_word(cmd_idx, w)});
                pushes++;
                cmd_idx = (cmd_idx + 1) % FRAME_CMDS;
            end
            if (mq.size() > 0 && mq[0].t <= cycle) begin
                check("no_overflow", (words_in - pops_now) < BUF_DEPTH, 1);
                if (first_wr_cyc < 0) begin
                    first_wr_cyc = cycle;
                    check("valid_before_first_word", video_valid, 0);
                end
                rdf_valid = 1'b1;
                rdf_dout  = mq[0].d;
                void'(mq.pop_front());
                words_in++;
            end else begin
                rdf_valid = 1'b0;
                rdf_dout  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(input int c, input int budget);
        int n = 0;
        while (cmd_idx != c && n < budget) begin step(); n++; end
        check($sformatf("wait_cmd_%0d", c), cmd_idx == c, 1);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin step(); n++; end
        check($sformatf("wait_frames_%0d", target), frames_done >= target, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr"},  af_addr_din, 0);
        check({tag, "_wr_en"}, af_wr_en, 0);
        check({tag, "_video"}, video, 0);
        check({tag, "_valid"}, video_valid, 0);
        check({tag, "_sof"},   video_sof, 0);
        check({tag, "_busy"},  busy, 0);
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        int p0, f0, n;

        // Reset state, then release with enable high.
        enable        = 1'b1;
        FR_frame_base = mkbase(6'd21);
        #3;
        check_outputs_zero("reset");
        step(); step();
        rst = 1'b1;

        // Base changes mid-frame: this frame keeps 21, the next uses 42.
        wait_cmd(150, 4000);
        FR_frame_base = mkbase(6'd42);
        wait_frames(2, 8000);

        // Consumer stalls for 200 cycles mid-row.
        wait_cmd(50, 6000);
        video_ready = 1'b0;
        repeat (50) step();
        p0 = pushes;
        repeat (150) step();
        check("stall_no_push", pushes - p0, 0);
        check("stall_buffer_filled", (words_in - pix_out / 4) >= BUF_DEPTH - 1, 1);
        video_ready = 1'b1;

        // Address FIFO full for 50 cycles mid-row.
        wait_cmd(ROW_CMDS + 40, 6000);
        af_full = 1'b1;
        p0 = pushes;
        repeat (50) step();
        check("full_no_push", pushes - p0, 0);
        af_full = 1'b0;

        // Random backpressure on both sides.
        for (int i = 0; i < 3000; i++) begin
            step();
            video_ready = ($urandom_range(0, 3) != 0);
            af_full     = ($urandom_range(0, 7) == 0);
        end
        step();
        video_ready = 1'b1;
        af_full     = 1'b0;

        // Asynchronous reset mid-row.
        wait_cmd(ROW_CMDS + 30, 10000);
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        step(); step();
        rst = 1'b1;
        f0 = frames_done;
        wait_frames(f0 + 1, 8000);

        // enable dropped mid-frame: the frame completes, then the FSM idles.
        wait_cmd(ROW_CMDS + 10, 8000);
        enable = 1'b0;
        f0 = frames_done;
        n = 0;
        while (busy && n < 8000) begin step(); n++; end
        check("busy_falls", busy, 0);
        check("frame_completed", frames_done, f0 + 1);
        check("pixel_index_at_idle", pix_idx, 0);
        check("cmd_index_at_idle", cmd_idx, 0);
        p0 = pushes;
        repeat (300) step();
        check("idle_no_push", pushes - p0, 0);
        check("idle_no_valid", video_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
